// File: rtl/counter_bank_if.sv
// AXI4-Lite register-bus bundle for counter_bank (12-bit address, 64-bit data).
interface counter_bank_if;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;

    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [2:0]        s_axi_arprot;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [1:0]        s_axi_rresp;
    logic [DATA_W-1:0] s_axi_rdata;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic [2:0]        s_axi_awprot;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [DATA_W-1:0] s_axi_wdata;
    logic [STRB_W-1:0] s_axi_wstrb;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [1:0]        s_axi_bresp;

    modport slave (
        input  s_axi_arvalid, s_axi_araddr, s_axi_arprot, s_axi_rready,
        input  s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
        input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_bready,
        output s_axi_arready, s_axi_rvalid, s_axi_rresp, s_axi_rdata,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp
    );

    modport master (
        output s_axi_arvalid, s_axi_araddr, s_axi_arprot, s_axi_rready,
        output s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
        output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_bready,
        input  s_axi_arready, s_axi_rvalid, s_axi_rresp, s_axi_rdata,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp
    );
endinterface

// File: rtl/counter_bank.sv
// Bank of NUM_CH free-running / event counters behind an AXI4-Lite register map.
// Define COUNTER_BANK_OVF_IRQ_EN to enable the masked overflow interrupt (irq) and IRQ_MASK.
module counter_bank #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned COUNT_W = 64
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_areset,
    counter_bank_if.slave             s_axi,
    input  logic [NUM_CH-1:0]         ev,
    output logic [NUM_CH*COUNT_W-1:0] cnt,
    output logic                      irq
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam logic [8:0] WA_INFO = 9'h000;
    localparam logic [8:0] WA_OVF  = 9'h002;
    localparam logic [8:0] WA_MASK = 9'h003;
    localparam logic [3:0] CH_PAGE = 4'h1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {SEL_INFO, SEL_OVF, SEL_MASK, SEL_COUNT, SEL_CTRL, SEL_ERR} sel_e;

    // Word-address decode; channel pages live at 0x100 + 0x10*i.
    function automatic sel_e decode(input logic [8:0] waddr);
        sel_e sel;
        sel = SEL_ERR;
        if (waddr == WA_INFO)      sel = SEL_INFO;
        else if (waddr == WA_OVF)  sel = SEL_OVF;
        else if (waddr == WA_MASK) sel = SEL_MASK;
        else if (waddr[8:5] == CH_PAGE && 32'(waddr[4:1]) < NUM_CH)
            sel = waddr[0] ? SEL_CTRL : SEL_COUNT;
        return sel;
    endfunction

    logic [COUNT_W-1:0] cnt_q  [NUM_CH];
    logic [COUNT_W-1:0] cnt_d  [NUM_CH];
    logic [2:0]         ctrl_q [NUM_CH];
    logic [2:0]         ctrl_d [NUM_CH];
    logic [NUM_CH-1:0]  ovf_q, ovf_d, ovf_set, ovf_clr, mask_q, mask_d, inc;
    logic               rvalid_q, rvalid_d, bvalid_q, bvalid_d;
    logic [1:0]         rresp_q, rresp_d, bresp_q, bresp_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d, rd_word, wbits;
    logic               ar_hs, wr_hs;
    sel_e               rsel, wsel;
    logic [3:0]         rch, wch;
    logic               unused_bits;

    assign unused_bits = ^{s_axi.s_axi_arprot, s_axi.s_axi_awprot,
                           s_axi.s_axi_araddr[2:0], s_axi.s_axi_awaddr[2:0]};

    assign ar_hs = s_axi.s_axi_arvalid && !rvalid_q;
    assign wr_hs = s_axi.s_axi_awvalid && s_axi.s_axi_wvalid && !bvalid_q && !s_axi_areset;
    assign rsel  = decode(s_axi.s_axi_araddr[11:3]);
    assign wsel  = decode(s_axi.s_axi_awaddr[11:3]);
    assign rch   = s_axi.s_axi_araddr[7:4];
    assign wch   = s_axi.s_axi_awaddr[7:4];

    assign s_axi.s_axi_arready = !rvalid_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = rresp_q;
    assign s_axi.s_axi_awready = wr_hs;
    assign s_axi.s_axi_wready  = wr_hs;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;

    // Read mux, sampled into rdata_q on the ar handshake.
    always_comb begin
        rd_word = '0;
        case (rsel)
            SEL_INFO: rd_word = {48'h0, 8'(COUNT_W), 8'(NUM_CH)};
            SEL_OVF:  rd_word = DATA_W'(ovf_q);
            SEL_MASK: rd_word = DATA_W'(mask_q);
            SEL_COUNT: for (int unsigned i = 0; i < NUM_CH; i++)
                if (rch == 4'(i)) rd_word = DATA_W'(cnt_q[i]);
            SEL_CTRL: for (int unsigned i = 0; i < NUM_CH; i++)
                if (rch == 4'(i)) rd_word = DATA_W'(ctrl_q[i]);
            default:  rd_word = '0;
        endcase
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = (rsel == SEL_ERR) ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi.s_axi_rready) begin
            rvalid_d = 1'b0;
        end
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = (wsel == SEL_ERR) ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi.s_axi_bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Counter datapath: a COUNT write beats a same-cycle increment.
    always_comb begin
        for (int unsigned b = 0; b < STRB_W; b++)
            wbits[b*8 +: 8] = {8{s_axi.s_axi_wstrb[b]}};
        ovf_set = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            inc[i]    = ctrl_q[i][0] && (!ctrl_q[i][2] || ev[i]);
            cnt_d[i]  = cnt_q[i];
            ctrl_d[i] = ctrl_q[i];
            if (wr_hs && wch == 4'(i) && wsel == SEL_COUNT) begin
                cnt_d[i] = COUNT_W'((DATA_W'(cnt_q[i]) & ~wbits) | (s_axi.s_axi_wdata & wbits));
            end else if (inc[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_set[i] = 1'b1;
                    cnt_d[i]   = ctrl_q[i][1] ? CNT_MAX : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + COUNT_W'(1);
                end
            end
            if (wr_hs && wch == 4'(i) && wsel == SEL_CTRL && s_axi.s_axi_wstrb[0])
                ctrl_d[i] = s_axi.s_axi_wdata[2:0];
        end
        ovf_clr = (wr_hs && wsel == SEL_OVF && s_axi.s_axi_wstrb[0]) ?
                  s_axi.s_axi_wdata[NUM_CH-1:0] : '0;
        ovf_d   = (ovf_q & ~ovf_clr) | ovf_set;
`ifdef COUNTER_BANK_OVF_IRQ_EN
        mask_d = mask_q;
        if (wr_hs && wsel == SEL_MASK && s_axi.s_axi_wstrb[0])
            mask_d = s_axi.s_axi_wdata[NUM_CH-1:0];
`else
        mask_d = '0;
`endif
    end

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            cnt[i*COUNT_W +: COUNT_W] = cnt_q[i];
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                ctrl_q[i] <= '0;
            end
            ovf_q    <= '0;
            mask_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                ctrl_q[i] <= ctrl_d[i];
            end
            ovf_q    <= ovf_d;
            mask_q   <= mask_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

`ifdef COUNTER_BANK_OVF_IRQ_EN
    logic irq_q, irq_d;

    always_comb irq_d = |(ovf_q & mask_q);

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) irq_q <= 1'b0;
        else              irq_q <= irq_d;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank (NUM_CH=4, COUNT_W=8); irq expectations follow COUNTER_BANK_OVF_IRQ_EN.
module tb_counter_bank;
    logic        clk;
    logic        rst;
    logic [3:0]  ev;
    logic [31:0] cnt;
    logic        irq;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          wr_cyc, rd_cyc, wc, dc;
    logic [63:0] d;
    logic [1:0]  resp;

`ifdef COUNTER_BANK_OVF_IRQ_EN
    localparam logic [63:0] IRQ_ON = 64'd1;
`else
    localparam logic [63:0] IRQ_ON = 64'd0;
`endif

    counter_bank_if bus ();

    counter_bank #(.NUM_CH(4), .COUNT_W(8)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .s_axi        (bus),
        .ev           (ev),
        .cnt          (cnt),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [63:0] wd, input logic [7:0] s,
                             input logic [3:0] evm, output logic [1:0] r);
        int n;
        @(negedge clk);
        bus.s_axi_awaddr = a; bus.s_axi_awprot = 3'b0; bus.s_axi_wdata = wd; bus.s_axi_wstrb = s;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        #1;
        n = 0;
        while (!(bus.s_axi_awready && bus.s_axi_wready) && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) timeout("aw_w_handshake");
        ev = evm;
        wr_cyc = cyc;
        @(posedge clk); #1;
        ev = '0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
        n = 0;
        while (!bus.s_axi_bvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) timeout("bvalid");
        r = bus.s_axi_bresp;
        @(posedge clk); #1;
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [63:0] rd, output logic [1:0] r);
        int n;
        @(negedge clk);
        bus.s_axi_araddr = a; bus.s_axi_arprot = 3'b0; bus.s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) timeout("ar_handshake");
        rd_cyc = cyc;
        @(posedge clk); #1;
        bus.s_axi_arvalid = 1'b0;
        n = 0;
        while (!bus.s_axi_rvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) timeout("rvalid");
        rd = bus.s_axi_rdata;
        r  = bus.s_axi_rresp;
        bus.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ev = '0;
        bus.s_axi_arvalid = 1'b0; bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_rready = 1'b0;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0;
        bus.s_axi_wvalid  = 1'b1; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_bready = 1'b0;
        #2;
        // Reset values, with aw/w valid held high to prove awready stays low.
        check("rst_arready", 64'(bus.s_axi_arready), 64'd1);
        check("rst_awready", 64'(bus.s_axi_awready), 64'd0);
        check("rst_wready",  64'(bus.s_axi_wready),  64'd0);
        check("rst_rvalid",  64'(bus.s_axi_rvalid),  64'd0);
        check("rst_bvalid",  64'(bus.s_axi_bvalid),  64'd0);
        check("rst_resps",   64'({bus.s_axi_rresp, bus.s_axi_bresp}), 64'd0);
        check("rst_irq",     64'(irq), 64'd0);
        check("rst_cnt",     64'(cnt), 64'd0);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        axi_read(12'h000, d, resp);
        check("info", d, 64'h0804);
        check("info_resp", 64'(resp), 64'd0);

        // Free-running channel 0: value equals enabled edges before the ar handshake.
        axi_write(12'h108, 64'h1, 8'hFF, 4'h0, resp);
        wc = wr_cyc;
        repeat (10) @(posedge clk);
        axi_read(12'h100, d, resp);
        check("ch0_free_count", d, 64'(rd_cyc - wc - 1));
        check("ch0_free_resp", 64'(resp), 64'd0);
        axi_write(12'h108, 64'h0, 8'hFF, 4'h0, resp);
        dc = wr_cyc;
        check("ch0_frozen_cnt", 64'(cnt[7:0]), 64'((dc - wc) & 8'hFF));

        // Wrap at all-ones on channel 1.
        axi_write(12'h110, 64'hFE, 8'hFF, 4'h0, resp);
        axi_write(12'h118, 64'h1, 8'hFF, 4'h0, resp);
        wc = wr_cyc;
        check("ch1_ff", 64'(cnt[15:8]), 64'hFF);
        @(posedge clk); #1;
        check("ch1_wrap", 64'(cnt[15:8]), 64'h00);
        axi_read(12'h010, d, resp);
        check("ovf_wrap", d, 64'h2);
        axi_write(12'h118, 64'h0, 8'hFF, 4'h0, resp);
        dc = wr_cyc;
        axi_read(12'h110, d, resp);
        check("ch1_after_wrap", d, 64'((254 + dc - wc) & 8'hFF));
        axi_write(12'h010, 64'h2, 8'h01, 4'h0, resp);
        axi_read(12'h010, d, resp);
        check("ovf_w1c", d, 64'h0);

        // Saturating mode holds all-ones and still flags overflow.
        axi_write(12'h110, 64'hFE, 8'hFF, 4'h0, resp);
        axi_write(12'h118, 64'h3, 8'hFF, 4'h0, resp);
        repeat (5) @(posedge clk);
        axi_read(12'h110, d, resp);
        check("ch1_sat", d, 64'hFF);
        axi_read(12'h118, d, resp);
        check("ch1_ctrl_rd", d, 64'h3);
        axi_read(12'h010, d, resp);
        check("ovf_sat", d, 64'h2);
        axi_write(12'h118, 64'h0, 8'hFF, 4'h0, resp);

        // Event-driven channel 2; channel 3 disabled sees the same pulses.
        axi_write(12'h128, 64'h5, 8'hFF, 4'h0, resp);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); ev = 4'b1100;
            @(negedge clk); ev = 4'b0000;
            @(negedge clk);
        end
        axi_read(12'h120, d, resp);
        check("ch2_events", d, 64'd3);
        axi_read(12'h130, d, resp);
        check("ch3_disabled", d, 64'd0);

        // COUNT write during an incrementing cycle, upper bits discarded.
        axi_write(12'h108, 64'h1, 8'hFF, 4'h0, resp);
        axi_write(12'h100, 64'h1234, 8'hFF, 4'h0, resp);
        wc = wr_cyc;
        axi_read(12'h100, d, resp);
        check("ch0_write_prio", d, 64'((8'h34 + rd_cyc - wc - 1) & 8'hFF));
        axi_write(12'h108, 64'h0, 8'hFF, 4'h0, resp);
        axi_write(12'h100, 64'hAB, 8'hFF, 4'h0, resp);
        axi_write(12'h100, 64'hFF00, 8'h02, 4'h0, resp);
        axi_read(12'h100, d, resp);
        check("strb_lane1_only", d, 64'hAB);
        axi_write(12'h100, 64'h5A5A, 8'h01, 4'h0, resp);
        axi_read(12'h100, d, resp);
        check("strb_lane0", d, 64'h5A);

        // Unmapped and out-of-range channel accesses.
        axi_read(12'h800, d, resp);
        check("unmapped_rd_data", d, 64'd0);
        check("unmapped_rd_resp", 64'(resp), 64'd2);
        axi_read(12'h008, d, resp);
        check("hole_rd_resp", 64'(resp), 64'd2);
        axi_write(12'h140, 64'h77, 8'hFF, 4'h0, resp);
        check("ch4_wr_resp", 64'(resp), 64'd2);
        axi_write(12'h148, 64'h1, 8'hFF, 4'h0, resp);
        check("ch4_ctrl_resp", 64'(resp), 64'd2);
        axi_read(12'h140, d, resp);
        check("ch4_rd", {62'(d), resp}, 64'd2);
        check("state_kept", 64'(cnt), 64'h0003FF5A);

        axi_write(12'h018, 64'h1, 8'hFF, 4'h0, resp);
        check("mask_wr_resp", 64'(resp), 64'd0);
        axi_read(12'h018, d, resp);
        check("mask_rd", d, IRQ_ON);

        // Overflow interrupt timing on channel 0.
        axi_write(12'h010, 64'hF, 8'h01, 4'h0, resp);
        axi_read(12'h010, d, resp);
        check("ovf_clear_all", d, 64'd0);
        axi_write(12'h100, 64'hFF, 8'hFF, 4'h0, resp);
        axi_write(12'h108, 64'h5, 8'hFF, 4'h0, resp);
        @(negedge clk); ev = 4'b0001;
        @(posedge clk); #1; ev = 4'b0000;
        check("ch0_ev_wrap", 64'(cnt[7:0]), 64'd0);
        check("irq_not_yet", 64'(irq), 64'd0);
        @(posedge clk); #1;
        check("irq_set", 64'(irq), IRQ_ON);
        axi_write(12'h010, 64'h1, 8'h01, 4'h0, resp);
        check("irq_cleared", 64'(irq), 64'd0);

        // Overflow set wins over a same-cycle W1C of the same bit.
        axi_write(12'h100, 64'hFF, 8'hFF, 4'h0, resp);
        axi_write(12'h010, 64'h1, 8'h01, 4'b0001, resp);
        axi_read(12'h010, d, resp);
        check("ovf_set_prio", d, 64'h1);
        check("irq_again", 64'(irq), IRQ_ON);

        // Reset with a read and a write response both outstanding.
        @(negedge clk);
        bus.s_axi_araddr = 12'h100; bus.s_axi_arvalid = 1'b1;
        bus.s_axi_awaddr = 12'h100; bus.s_axi_wdata = 64'h11; bus.s_axi_wstrb = 8'hFF;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_arvalid = 1'b0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        check("inflight_valids", 64'({bus.s_axi_rvalid, bus.s_axi_bvalid}), 64'd3);
        check("inflight_cnt0", 64'(cnt[7:0]), 64'h11);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valids", 64'({bus.s_axi_rvalid, bus.s_axi_bvalid}), 64'd0);
        check("mid_rst_cnt", 64'(cnt), 64'd0);
        check("mid_rst_irq", 64'(irq), 64'd0);
        check("mid_rst_arready", 64'(bus.s_axi_arready), 64'd1);
        @(negedge clk); rst = 1'b0;
        bus.s_axi_rready = 1'b1; bus.s_axi_bready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valids", 64'({bus.s_axi_rvalid, bus.s_axi_bvalid}), 64'd0);
        check("post_rst_disabled", 64'(cnt), 64'd0);
        bus.s_axi_rready = 1'b0; bus.s_axi_bready = 1'b0;
        axi_read(12'h108, d, resp);
        check("post_rst_ctrl0", d, 64'd0);
        axi_read(12'h010, d, resp);
        check("post_rst_ovf", d, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
